uart_rx_frame: RTL and testbench

UART_RX_FRAME -- requirements
Module: uart_rx_frame

---
 rtl/uart_pkg.sv | 22 ++
 rtl/uart_rx_sync.sv | 34 +++
 rtl/uart_rx_frame.sv | 140 ++++++++++++++
 tb/tb_uart_rx_frame.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions used by the receiver, the baud generator and the transmitter.
//   DATA_BITS  data bits per frame
//   START_IDX  bit index of the start bit
//   STOP_IDX   bit index of the stop bit
//   END_IDX    bit index reported once the frame has ended
//   rx_state_e receiver frame FSM states
package uart_pkg;

  localparam int unsigned DATA_BITS = 8;

  localparam logic [3:0] START_IDX = 4'd0;
  localparam logic [3:0] STOP_IDX  = 4'd9;
  localparam logic [3:0] END_IDX   = 4'd10;

  typedef enum logic [1:0] {
    StIdle,
    StArm,
    StRecv,
    StFlush
  } rx_state_e;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous serial line plus falling-edge detect.
//   clk      in   system clock
//   rst      in   synchronous active-high reset; all flops reset to the idle level 1
//   rx       in   asynchronous serial line
//   rx_s     out  synchronized line
//   rx_fall  out  previous rx_s = 1 and current rx_s = 0
module uart_rx_sync (
  input  logic clk,
  input  logic rst,
  input  logic rx,
  output logic rx_s,
  output logic rx_fall
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      meta_q <= rx;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign rx_s    = sync_q;
  assign rx_fall = prev_q & ~sync_q;

endmodule

// File: rtl/uart_rx_frame.sv
// UART receive framer. Detects a start edge, asks the external baud generator to run a
// frame, samples the synchronized line on each mid-bit pulse and delivers the byte through
// a registered valid/ready holding register.
//   clk          in   system clock
//   rst          in   synchronous active-high reset
//   rx           in   asynchronous serial line, idle 1
//   baud_start   out  one-cycle request to start the baud generator
//   baud_busy    in   baud generator is running a frame
//   baud_mid     in   one-cycle pulse at the middle of each bit
//   baud_counte  in   bit index: 0 start, 1..8 data, 9 stop, 10 end
//   rx_data      out  received byte
//   rx_valid     out  rx_data holds an unread byte
//   rx_ready     in   consumer accepts rx_data
//   frame_err    out  one-cycle pulse when the stop bit samples 0
//   overrun_err  out  one-cycle pulse when a good byte is dropped
//   rx_busy      out  FSM is not idle
module uart_rx_frame #(
  parameter int unsigned DATA_BITS = uart_pkg::DATA_BITS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  output logic                 baud_start,
  input  logic                 baud_busy,
  input  logic                 baud_mid,
  input  logic [3:0]           baud_counte,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 overrun_err,
  output logic                 rx_busy
);

  import uart_pkg::*;

  logic rx_s;
  logic rx_fall;

  uart_rx_sync u_sync (
    .clk     (clk),
    .rst     (rst),
    .rx      (rx),
    .rx_s    (rx_s),
    .rx_fall (rx_fall)
  );

  rx_state_e            state_q, state_d;
  logic                 pend_q, pend_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 ferr_q, ferr_d;
  logic                 ovr_q, ovr_d;
  logic                 deliver;

  always_comb begin
    state_d    = state_q;
    pend_d     = pend_q;
    shift_d    = shift_q;
    ferr_d     = 1'b0;
    deliver    = 1'b0;
    baud_start = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (rx_fall || pend_q) begin
          state_d = StArm;
          pend_d  = 1'b0;
        end
      end
      StArm: begin
        baud_start = 1'b1;
        state_d    = StRecv;
      end
      StRecv: begin
        if (baud_mid) begin
          if (baud_counte == START_IDX) begin
            // Line back high at mid start bit: a glitch, not a frame.
            if (rx_s) state_d = StFlush;
          end else if (baud_counte < STOP_IDX) begin
            shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
          end else if (baud_counte == STOP_IDX) begin
            deliver = rx_s;
            ferr_d  = ~rx_s;
            state_d = StFlush;
          end
        end
      end
      StFlush: begin
        // A start edge can arrive while the generator finishes the stop bit; remember it.
        if (rx_fall) pend_d = 1'b1;
        if (!baud_busy) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    ovr_d   = 1'b0;
    if (deliver) begin
      if (valid_q && !rx_ready) begin
        ovr_d = 1'b1;
      end else begin
        data_d  = shift_q;
        valid_d = 1'b1;
      end
    end else if (valid_q && rx_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      pend_q  <= 1'b0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
    end
  end

  assign rx_data     = data_q;
  assign rx_valid    = valid_q;
  assign frame_err   = ferr_q;
  assign overrun_err = ovr_q;
  assign rx_busy     = (state_q != StIdle);

endmodule

// File: tb/tb_uart_rx_frame.sv
module tb_uart_rx_frame;
  import uart_pkg::*;

  localparam int BAUD = 15;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx = 1'b1;
  logic       rx_ready = 1'b0;
  logic       baud_start, baud_busy, baud_mid;
  logic [3:0] baud_counte;
  logic [7:0] rx_data;
  logic       rx_valid, frame_err, overrun_err, rx_busy;

  always #5 clk = ~clk;

  uart_rx_frame #(.DATA_BITS(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .rx          (rx),
    .baud_start  (baud_start),
    .baud_busy   (baud_busy),
    .baud_mid    (baud_mid),
    .baud_counte (baud_counte),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_ready    (rx_ready),
    .frame_err   (frame_err),
    .overrun_err (overrun_err),
    .rx_busy     (rx_busy)
  );

  // Baud generator stand-in: one BAUD-cycle period per bit, mid pulse halfway through.
  logic       g_busy;
  logic [3:0] g_idx;
  int         g_cnt;

  always @(posedge clk) begin
    if (rst) begin
      g_busy <= 1'b0;
      g_idx  <= END_IDX;
      g_cnt  <= 0;
    end else if (!g_busy) begin
      if (baud_start) begin
        g_busy <= 1'b1;
        g_idx  <= START_IDX;
        g_cnt  <= 0;
      end
    end else if (g_cnt == BAUD - 1) begin
      g_cnt <= 0;
      if (g_idx == STOP_IDX) begin
        g_idx  <= END_IDX;
        g_busy <= 1'b0;
      end else begin
        g_idx <= g_idx + 4'd1;
      end
    end else begin
      g_cnt <= g_cnt + 1;
    end
  end

  assign baud_busy   = g_busy;
  assign baud_counte = g_idx;
  assign baud_mid    = g_busy && (g_cnt == BAUD / 2);

  // Model: every frame the generator runs has a known outcome; at its stop-bit sample
  // point the outcome decides what the holding register must show next cycle.
  typedef enum {KGood, KFerr, KFalse} kind_e;
  typedef struct {
    kind_e      k;
    logic [7:0] b;
  } exp_t;

  exp_t       q[$];
  logic       m_valid, m_ferr, m_ovr;
  logic [7:0] m_data;

  always @(posedge clk) begin
    exp_t e;
    if (rst) begin
      m_valid <= 1'b0;
      m_data  <= 8'h00;
      m_ferr  <= 1'b0;
      m_ovr   <= 1'b0;
      q.delete();
    end else begin
      m_ferr <= 1'b0;
      m_ovr  <= 1'b0;
      if (baud_mid && baud_counte == STOP_IDX && q.size() > 0) begin
        e = q.pop_front();
        if (e.k == KFerr) m_ferr <= 1'b1;
        if (e.k == KGood) begin
          if (m_valid && !rx_ready) m_ovr <= 1'b1;
          else begin
            m_data  <= e.b;
            m_valid <= 1'b1;
          end
        end else if (m_valid && rx_ready) begin
          m_valid <= 1'b0;
        end
      end else if (m_valid && rx_ready) begin
        m_valid <= 1'b0;
      end
    end
  end

  int         n_vec = 0;
  int         n_bad = 0;
  int         n_ferr = 0;
  int         n_ovr = 0;
  bit         chk_en = 1'b0;
  logic       prev_v = 1'b0;
  logic [7:0] got[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("model_valid", {31'd0, rx_valid}, {31'd0, m_valid});
      check("model_data", {24'd0, rx_data}, {24'd0, m_data});
      check("model_ferr", {31'd0, frame_err}, {31'd0, m_ferr});
      check("model_ovr", {31'd0, overrun_err}, {31'd0, m_ovr});
      if (frame_err) n_ferr++;
      if (overrun_err) n_ovr++;
      if (rx_valid && !prev_v) got.push_back(rx_data);
      prev_v = rx_valid;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic v);
    rx = v;
    repeat (BAUD) step();
  endtask

  task automatic expect_frame(input kind_e k, input logic [7:0] b);
    exp_t e;
    e.k = k;
    e.b = b;
    q.push_back(e);
  endtask

  // rdy_at_stop raises rx_ready for exactly the cycle the stop bit is sampled.
  task automatic send_frame(input logic [7:0] b, input logic stop, input kind_e k,
                            input int gap, input bit rdy_at_stop);
    expect_frame(k, b);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    rx = stop;
    for (int i = 0; i < BAUD; i++) begin
      if (rdy_at_stop) rx_ready = baud_mid && (baud_counte == STOP_IDX);
      step();
    end
    if (rdy_at_stop) rx_ready = 1'b0;
    rx = 1'b1;
    repeat (gap) step();
  endtask

  task automatic wait_gen_idle();
    int n = 0;
    while (baud_busy && n < 400) begin
      step();
      n++;
    end
    check("gen_idle_timeout", {31'd0, baud_busy}, 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"}, {31'd0, rx_valid}, 32'd0);
    check({tag, "_data"}, {24'd0, rx_data}, 32'd0);
    check({tag, "_busy"}, {31'd0, rx_busy}, 32'd0);
    check({tag, "_start"}, {31'd0, baud_start}, 32'd0);
    check({tag, "_ferr"}, {31'd0, frame_err}, 32'd0);
    check({tag, "_ovr"}, {31'd0, overrun_err}, 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int f0, o0, g0;
    rst = 1'b1;
    repeat (3) step();
    check_reset_outputs("reset");
    chk_en = 1'b1;
    rst = 1'b0;
    repeat (5) step();

    // Good frame held until accepted.
    rx_ready = 1'b0;
    send_frame(8'hA5, 1'b1, KGood, 30, 1'b0);
    check("a5_valid", {31'd0, rx_valid}, 32'd1);
    check("a5_data", {24'd0, rx_data}, 32'h0000_00A5);
    repeat (10) step();
    check("a5_hold", {24'd0, rx_data}, 32'h0000_00A5);
    rx_ready = 1'b1;
    step();
    rx_ready = 1'b0;
    check("a5_cleared", {31'd0, rx_valid}, 32'd0);

    // False start: short low glitch.
    f0 = n_ferr;
    expect_frame(KFalse, 8'h00);
    rx = 1'b0;
    repeat (3) step();
    rx = 1'b1;
    repeat (5) step();
    check("false_busy", {31'd0, rx_busy}, 32'd1);
    wait_gen_idle();
    step();
    check("false_idle", {31'd0, rx_busy}, 32'd0);
    check("false_valid", {31'd0, rx_valid}, 32'd0);
    check("false_no_ferr", n_ferr - f0, 32'd0);

    // Bad stop bit.
    f0 = n_ferr;
    send_frame(8'h3C, 1'b0, KFerr, 30, 1'b0);
    check("ferr_pulses", n_ferr - f0, 32'd1);
    check("ferr_valid", {31'd0, rx_valid}, 32'd0);

    // Overrun, then load with ready in the load cycle.
    o0 = n_ovr;
    send_frame(8'h11, 1'b1, KGood, 30, 1'b0);
    send_frame(8'h22, 1'b1, KGood, 30, 1'b0);
    check("ovr_keep_data", {24'd0, rx_data}, 32'h0000_0011);
    check("ovr_valid", {31'd0, rx_valid}, 32'd1);
    check("ovr_pulses", n_ovr - o0, 32'd1);
    send_frame(8'h22, 1'b1, KGood, 30, 1'b1);
    check("ready_load_data", {24'd0, rx_data}, 32'h0000_0022);
    check("ready_load_valid", {31'd0, rx_valid}, 32'd1);
    check("ready_load_no_ovr", n_ovr - o0, 32'd1);
    rx_ready = 1'b1;
    step();
    rx_ready = 1'b0;

    // Back-to-back frames, no idle gap.
    rx_ready = 1'b1;
    g0 = got.size();
    send_frame(8'h55, 1'b1, KGood, 0, 1'b0);
    send_frame(8'hAA, 1'b1, KGood, 40, 1'b0);
    check("b2b_count", got.size() - g0, 32'd2);
    if (got.size() >= g0 + 2) begin
      check("b2b_first", {24'd0, got[g0]}, 32'h0000_0055);
      check("b2b_second", {24'd0, got[g0+1]}, 32'h0000_00AA);
    end
    rx_ready = 1'b0;

    // Reset during data bit 4, then a clean frame.
    expect_frame(KGood, 8'h00);
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b0);
    repeat (7) step();
    rst = 1'b1;
    rx = 1'b1;
    step();
    rst = 1'b0;
    check_reset_outputs("midrst");
    repeat (20) step();
    send_frame(8'h0F, 1'b1, KGood, 30, 1'b0);
    check("post_rst_valid", {31'd0, rx_valid}, 32'd1);
    check("post_rst_data", {24'd0, rx_data}, 32'h0000_000F);
    rx_ready = 1'b1;
    step();
    rx_ready = 1'b0;
    repeat (3) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
